// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Consumers import this package; MEM_ARB_FIXED_PRIO_EN selects the arbitration flavour.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 32;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-requester winner select. Round-robin on last_grant by default;
// fixed priority (port 0 wins ties, no last_grant) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic       last_grant,
`endif
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req_valid;
    grant_idx   = PORT_IFETCH;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (!req_valid[0] && req_valid[1]) grant_idx = PORT_DATA;
`else
    // On a tie the port that did not win last time goes next.
    if (&req_valid) grant_idx = ~last_grant;
    else if (req_valid[1]) grant_idx = PORT_DATA;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-port Mem_D32b_A16b memory: two requesters, one access per 3 cycles.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready offered to the winner
// ACCESS | address/data/write presented to the memory
// RESP   | read data arriving on mem_data_out; completion registered on exit
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_address0,
  input  logic [ADDR_W-1:0] req_address1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant_valid;
  logic       grant_idx;
  logic       accept;
  logic       lat_idx;
  logic       lat_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
  rr_pick2 u_pick (
    .req_valid   (req_valid),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );
`else
  logic last_grant;

  rr_pick2 u_pick (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid && !reset) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The memory-drive registers double as the address/wdata latches: they are
  // loaded at acceptance and simply hold through ACCESS, RESP and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_idx     <= PORT_IFETCH;
      lat_write   <= 1'b0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant  <= PORT_DATA;
`endif
    end else begin
      resp_valid <= '0;
      mem_write  <= 1'b0;
      if (accept) begin
        lat_idx     <= grant_idx;
        lat_write   <= req_write[grant_idx];
        mem_write   <= req_write[grant_idx];
        mem_address <= grant_idx ? req_address1 : req_address0;
        mem_data_in <= grant_idx ? req_wdata1 : req_wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant  <= grant_idx;
`endif
      end
      if (state == RESP) begin
        resp_valid[lat_idx] <= 1'b1;
        if (!lat_write) resp_rdata <= mem_data_out;
      end
    end
  end

endmodule
